// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Define ALU_ARB_STATS_EN to add saturating per-port grant counters.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [OPW-1:0]   req0_aluop,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_out,
  output logic             resp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [OPW-1:0]   req1_aluop,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_out,
  output logic             resp1_zero,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [OPW-1:0]   alu_aluop,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [OPW-1:0]   aop_q, aop_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             sel;
  logic             take;
  logic             rel;

  // Ties go to whichever port did not win last time.
  always_comb begin
    sel = 1'b0;
    unique case (1'b1)
      req0_valid && req1_valid: sel = ~last_q;
      req1_valid && !req0_valid: sel = 1'b1;
      default: sel = 1'b0;
    endcase
  end

  assign take = reset_n && (state_q == IDLE)
             && (req0_valid || req1_valid);
  assign req0_ready = take && !sel;
  assign req1_ready = take && sel;
  assign rel = (state_q == RESP)
            && (gnt_q ? resp1_ready : resp0_ready);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    aop_d   = aop_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          op1_d   = sel ? req1_op1 : req0_op1;
          op2_d   = sel ? req1_op2 : req0_op2;
          aop_d   = sel ? req1_aluop : req0_aluop;
          gnt_d   = sel;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_out;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        if (rel) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      aop_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      aop_q   <= aop_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign alu_op1     = op1_q;
  assign alu_op2     = op2_q;
  assign alu_aluop   = aop_q;
  assign resp0_valid = (state_q == RESP) && !gnt_q;
  assign resp1_valid = (state_q == RESP) && gnt_q;
  assign resp0_out   = res_q;
  assign resp1_out   = res_q;
  assign resp0_zero  = zero_q;
  assign resp1_zero  = zero_q;
  assign busy        = (state_q != IDLE);

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (req0_valid && req0_ready && cnt0_q != 16'hFFFF)
        cnt0_q <= cnt0_q + 16'd1;
      if (req1_valid && req1_ready && cnt1_q != 16'hFFFF)
        cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule
